mac_feeder: RTL
===============

// Module: mac_feeder
// PURPOSE
// Upstream sequencer for the pipelined MAC; the MAC sits directly after this block.
// - Accepts (a, b, bias) operand pairs over a valid/ready stream.
// - Groups every LEN accepted pairs into one dot product and drives the MAC's
//   input0/input1/input_valid/init_acc/init_value through registers.
// - Waits for the MAC pipeline to drain, then presents the MAC result on a
//   valid/ready result port.
// PARAMETERS
// INW   16  operand width; equals the MAC's INW.
// OUTW  64  accumulator/result width; equals the MAC's OUTW.
// LEN   4   pairs per dot product; must be >= 1.
// PORTS
// clk             in   1     clock; all logic on posedge.
// reset           in   1     synchronous, active-high reset.
// in_a            in   INW   signed operand a.
// in_b            in   INW   signed operand b.
// in_bias         in   INW   signed init value; sampled only with the first pair of a vector.
// in_valid        in   1     upstream pair valid.
// in_ready        out  1     block accepts a pair this cycle.
// mac_in0         out  INW   to MAC input0 (registered).
// mac_in1         out  INW   to MAC input1 (registered).
// mac_init_value  out  INW   to MAC init_value (registered).
// mac_init_acc    out  1     to MAC init_acc (registered).
// mac_valid       out  1     to MAC input_valid (registered).
// mac_out         in   OUTW  from MAC out.
// res_data        out  OUTW  dot-product result.
// res_valid       out  1     result valid.
// res_ready       in   1     downstream accepts result.
// BEHAVIOUR
// - Accept = in_valid && in_ready.
// - States: RUN, W1, W2, OUT. Counter cnt, width $clog2(LEN+1).
// - RUN: in_ready=1.
//   - Each accept: cnt++.
//   - Accept with cnt==LEN-1: cnt<=0, go to W1.
// - W1 -> W2 -> OUT unconditionally, one cycle each. in_ready=0 throughout.
// - OUT: res_valid=1, res_data=mac_out (stable; the MAC sees no valid/init here).
//   - res_valid && res_ready: go to RUN.
//   - res_valid stays high and res_data stays constant until accepted.
// - MAC drive, registered from cycle t to t+1:
//   - mac_valid <= accept.
//   - mac_in0 <= in_a, mac_in1 <= in_b on accept; hold otherwise.
//   - mac_init_acc <= accept && cnt==0.
//   - mac_init_value <= in_bias when accept && cnt==0; hold otherwise.
// - Latency: last pair accepted in cycle L -> res_valid first high in cycle L+3.
//   - L+1: mac_valid high.
//   - Edge L+2: MAC product reg loads.
//   - Edge L+3: MAC out updates.
// - Same-cycle init_acc and input_valid at the MAC for the first pair is legal.
//   - init loads out at edge t+2; that pair's product accumulates at edge t+3.
// - init_acc never overlaps the previous vector's final accumulation: no pair is
//   accepted from W1 through OUT.
// - in_valid gaps inside a vector: no accept, no count, mac_valid=0 next cycle.
// - LEN==1: every accept has cnt==0, so it asserts init and goes straight to W1.
// - Arithmetic is done entirely in the MAC; this block does no width conversion.
// - Reset (any state, any cycle): state=RUN, cnt=0.
//   - Outputs: mac_in0/mac_in1/mac_init_value=0, mac_init_acc=0, mac_valid=0.
//   - res_valid=0, in_ready=1 in the first post-reset cycle.
//   - A partial vector in flight is discarded. The MAC is reset by the same reset.
// TESTING
// Bench instantiates mac_feeder -> MAC (INW=16, OUTW=64, LEN=4); MAC out feeds mac_out.
// 1. Basic: a=1,2,3,4; b=5,6,7,8; bias=10; back-to-back valid.
//    -> res_data=80; res_valid in cycle L+3.
// 2. Signed: a=-3,100,-32768,1; b=7,-2,2,-1; bias=-5.
//    -> res_data=-5-21-200-65536-1=-65763.
// 3. Gaps and backpressure: scenario 1 with in_valid low 2 cycles between pairs; res_ready low 5 cycles.
//    -> res_data=80 held stable; in_ready=0 until accepted.
// 4. Back-to-back vectors, no bias carry-over:
//    - vector A = scenario 1;
//    - vector B: a=1,1,1,1; b=2,2,2,2; bias=0.
//    -> results 80 then 8; vector B first accepted the cycle after the A handshake.
// 5. Reset mid-vector: assert reset after 2 pairs of a vector.
//    -> all outputs 0, in_ready=1; the next full vector of scenario 1 yields 80.
// 6. Parameter LEN=1: a=-4, b=9, bias=3.
//    -> res_data=-33; mac_init_acc and mac_valid both high in the same cycle.

Source files
------------

// File: rtl/mac_feeder.sv
// mac_feeder: groups LEN operand pairs into one dot product, drives a pipelined
// MAC through registers, waits for the pipeline to drain, then presents the result.
module mac_feeder #(
  parameter int INW  = 16,
  parameter int OUTW = 64,
  parameter int LEN  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [INW-1:0]  in_a,
  input  logic [INW-1:0]  in_b,
  input  logic [INW-1:0]  in_bias,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [INW-1:0]  mac_in0,
  output logic [INW-1:0]  mac_in1,
  output logic [INW-1:0]  mac_init_value,
  output logic            mac_init_acc,
  output logic            mac_valid,
  input  logic [OUTW-1:0] mac_out,
  output logic [OUTW-1:0] res_data,
  output logic            res_valid,
  input  logic            res_ready
);

  localparam int CW = $clog2(LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  typedef enum logic [1:0] {RUN, W1, W2, OUT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          accept;
  logic          first;

  // Pairs are only taken while running; W1/W2 cover the MAC drain so that the
  // next vector's init never collides with the last accumulation.
  assign in_ready = (state == RUN);
  assign accept   = in_valid && in_ready;
  assign first    = (cnt == '0);
  // The MAC sees no valid/init while in OUT, so its output is already stable.
  assign res_data = mac_out;

  // State and pair counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state: count accepts, drain two cycles, hold result until taken.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    res_valid = 1'b0;
    case (state)
      RUN: begin
        if (accept) begin
          if (cnt == LAST) begin
            cnt_nxt   = '0;
            state_nxt = W1;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      W1: state_nxt = W2;
      W2: state_nxt = OUT;
      OUT: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Registered MAC drive; operands and init value hold between accepts.
  always_ff @(posedge clk) begin
    if (reset) begin
      mac_in0        <= '0;
      mac_in1        <= '0;
      mac_init_value <= '0;
      mac_init_acc   <= 1'b0;
      mac_valid      <= 1'b0;
    end else begin
      mac_valid    <= accept;
      mac_init_acc <= accept && first;
      if (accept) begin
        mac_in0 <= in_a;
        mac_in1 <= in_b;
      end
      if (accept && first) mac_init_value <= in_bias;
    end
  end

endmodule
